mem_ctrl_arb: RTL and testbench
===============================

Name: mem_ctrl_arb

Overview:
- Parametrised successor memory controller between the IF/MEM stages and the single byte-wide RAM port.
- Arbitrates an instruction-fetch channel and a load/store channel with fixed priority.
- Serialises each access into per-byte RAM cycles, pipelined one byte per cycle, with configurable RAM read latency.
- Supports byte/half/word/dword sizes, write bypass of the latency wait, and branch-flush cancellation of in-flight fetches.

Parameters:
- ADDR_W, 32, width of all addresses.
- DATA_W, 32, data/instruction word width; 32 or 64 only.
- RAM_LAT, 1, cycles from ram_addr driven to matching byte on ram_din; range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  branch mispredict; cancels an in-flight fetch
- ram_din  in  8  RAM read byte
- ram_dout  out  8  RAM write byte
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write the current byte
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_ready  out  1  fetch request accepted this cycle
- inst_valid  out  1  one-cycle pulse: inst_data valid
- inst_data  out  DATA_W  fetched word, little-endian
- inst_addr_o  out  ADDR_W  address of the fetched word
- data_req  in  1  load/store request
- data_we  in  1  1 = store
- data_addr  in  ADDR_W  byte address
- data_wdata  in  DATA_W  store data, LSB first
- data_size  in  2  00 byte, 01 half, 10 word, 11 dword (clamped to DATA_W/8)
- data_ready  out  1  load/store accepted this cycle
- data_valid  out  1  one-cycle pulse: load data valid or store done
- data_rdata  out  DATA_W  load data, zero-extended
- busy  out  1  transaction in progress

Behaviour:
- Reset: every output 0, FSM IDLE, all counters and pipeline tags cleared. Reset mid-transaction aborts it immediately; no valid pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, acceptance:
  - data_ready = (state==IDLE).
  - inst_ready = (state==IDLE) & !data_req & !flush.
  - Data wins a simultaneous request.
  - The accepted request (address, size, wdata, we, channel) is latched at edge T.
- Byte count N: 1/2/4/8 per size; fetch always N = DATA_W/8. A size code that exceeds DATA_W/8 is clamped to DATA_W/8.
- ISSUE, cycles T+1 .. T+N: ram_addr = addr + k for k = 0..N-1, modulo 2^ADDR_W. Misaligned addresses are legal.
  - Store: ram_wr = 1, ram_dout = wdata[8k+7:8k].
  - Load/fetch: ram_wr = 0.
- Store completion: after the last byte, go to DONE; data_valid pulses in cycle T+N+1. There is no latency wait.
- Read completion:
  - A RAM_LAT-deep tag shift register marks each issued read byte.
  - Byte k is captured from ram_din at the end of cycle T+1+k+RAM_LAT into bits [8k+7:8k].
  - After the last issue the FSM enters DRAIN until all N bytes are captured, then DONE.
  - The valid pulse occurs in cycle T+N+RAM_LAT+1; unused upper bytes read 0.
- DONE lasts one cycle:
  - Pulses data_valid, or inst_valid with inst_addr_o = latched address.
  - Next state is IDLE.
  - The back-to-back gap between transactions is exactly one IDLE cycle.
- Outside store issue: ram_wr = 0 always. ram_addr and ram_dout hold their last value.
- busy = (state != IDLE).
- Output hold: inst_data and data_rdata hold until the next completion of the same channel.
- flush:
  - Flush while the active transaction is a fetch (ISSUE/DRAIN/DONE): abort. No inst_valid is produced, pending tags are discarded, and the FSM returns to IDLE next cycle. Bytes arriving later are ignored.
  - Flush during a data transaction is ignored; stores and loads always complete.
  - Flush in IDLE blocks fetch acceptance that cycle only; a data request is still accepted.
- inst_valid and data_valid are never high in the same cycle.

Test Plan:
- Fetch, inst_req=1, inst_addr=0x1000, RAM_LAT=1, bytes 13 05 00 00 -> ram_addr 0x1000..0x1003 in cycles T+1..T+4; inst_valid at T+6 with inst_data=0x00000513, inst_addr_o=0x1000.
- Simultaneous inst_req and data_req (load word @0x20) -> data_ready=1, inst_ready=0; load completes; fetch accepted in the IDLE cycle after DONE.
- Store half, data_wdata=0xAABBCCDD @0x3FFFF -> ram_wr=1 with ram_dout DD @0x3FFFF then CC @0x40000; data_valid at T+3. Mem @0x3FFFF/0x40000 = DD/CC, 0x40001 untouched.
- Load byte @0x7, ram_din=0x80, RAM_LAT=3 -> data_rdata=0x00000080 (zero-extended); data_valid at T+5.
- flush asserted at T+3 of a fetch -> no inst_valid, busy=0 at T+4; a new fetch accepted at T+4 returns the correct word.
- rst asserted mid-store after 2 of 4 bytes -> all outputs 0 immediately; no data_valid; ram_wr=0.

Source files
------------

// File: rtl/mem_ctrl_arb.sv
// Byte-serial memory controller: arbitrates fetch and load/store onto one byte-wide RAM port,
// issuing one byte per cycle and collecting read bytes after a fixed RAM latency.
module mem_ctrl_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [1:0]        data_size,
  output logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              busy
);

  localparam int NB = DATA_W / 8;
  localparam int CW = 4;
  localparam logic [1:0]    MAX_SZ    = (DATA_W == 64) ? 2'd3 : 2'd2;
  localparam logic [CW-1:0] LAST_INST = CW'(NB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                is_inst_q, is_inst_d;
  logic [CW-1:0]       last_q, last_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cap_q, cap_d;
  logic [RAM_LAT-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic                inst_valid_q, inst_valid_d;
  logic                data_valid_q, data_valid_d;
  logic [DATA_W-1:0]   inst_data_q, inst_data_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic [ADDR_W-1:0]   inst_addr_o_q, inst_addr_o_d;
  logic                busy_q, busy_d;

  logic                accept_data_s, accept_inst_s, issue_rd_s, cap_s, abort_s;
  logic [1:0]          sz_s;

  // Next-state, RAM-side sequencing and read-byte collection
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    is_inst_d     = is_inst_q;
    last_d        = last_q;
    idx_d         = idx_q;
    ram_addr_d    = ram_addr_q;
    ram_dout_d    = ram_dout_q;
    ram_wr_d      = 1'b0;
    inst_valid_d  = 1'b0;
    data_valid_d  = 1'b0;
    inst_data_d   = inst_data_q;
    data_rdata_d  = data_rdata_q;
    inst_addr_o_d = inst_addr_o_q;

    accept_data_s = (state_q == IDLE) && data_req;
    accept_inst_s = (state_q == IDLE) && !data_req && inst_req && !flush;
    issue_rd_s    = (state_q == ISSUE) && !we_q;
    cap_s         = tag_q[RAM_LAT-1];
    abort_s       = is_inst_q && flush && (state_q != IDLE);
    sz_s          = (data_size > MAX_SZ) ? MAX_SZ : data_size;

    // each issued read byte travels RAM_LAT cycles before it is captured
    tag_d = (tag_q << 1'b1) | RAM_LAT'(issue_rd_s);
    cap_d = cap_s ? cap_q + CW'(1) : cap_q;
    for (int b = 0; b < NB; b++) begin
      rbuf_d[8*b +: 8] = (cap_s && (cap_q == CW'(b))) ? ram_din : rbuf_q[8*b +: 8];
    end

    case (state_q)
      IDLE: begin
        if (accept_data_s) begin
          state_d    = ISSUE;
          addr_d     = data_addr;
          wdata_d    = data_wdata;
          we_d       = data_we;
          is_inst_d  = 1'b0;
          last_d     = (CW'(1) << sz_s) - CW'(1);
          idx_d      = '0;
          cap_d      = '0;
          rbuf_d     = '0;
          ram_addr_d = data_addr;
          ram_dout_d = data_wdata[7:0];
          ram_wr_d   = data_we;
        end else if (accept_inst_s) begin
          state_d    = ISSUE;
          addr_d     = inst_addr;
          we_d       = 1'b0;
          is_inst_d  = 1'b1;
          last_d     = LAST_INST;
          idx_d      = '0;
          cap_d      = '0;
          rbuf_d     = '0;
          ram_addr_d = inst_addr;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (idx_q == last_q) begin
          // stores need no latency wait
          state_d      = we_q ? DONE : DRAIN;
          data_valid_d = we_q;
        end else begin
          idx_d      = idx_q + CW'(1);
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_dout_d = 8'(wdata_q >> {idx_q + CW'(1), 3'b000});
          ram_wr_d   = we_q;
        end
      end
      DRAIN: begin
        if (cap_s && (cap_q == last_q)) begin
          state_d = DONE;
          if (is_inst_q) begin
            inst_valid_d  = 1'b1;
            inst_data_d   = rbuf_d;
            inst_addr_o_d = addr_q;
          end else begin
            data_valid_d = 1'b1;
            data_rdata_d = rbuf_d;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // a mispredicted fetch is dropped together with any bytes still in flight
    if (abort_s) begin
      state_d       = IDLE;
      tag_d         = '0;
      cap_d         = '0;
      inst_valid_d  = 1'b0;
      inst_data_d   = inst_data_q;
      inst_addr_o_d = inst_addr_o_q;
    end else begin
      tag_d = tag_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      is_inst_q     <= 1'b0;
      last_q        <= '0;
      idx_q         <= '0;
      cap_q         <= '0;
      tag_q         <= '0;
      rbuf_q        <= '0;
      ram_addr_q    <= '0;
      ram_dout_q    <= '0;
      ram_wr_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      data_rdata_q  <= '0;
      inst_addr_o_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      is_inst_q     <= is_inst_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      cap_q         <= cap_d;
      tag_q         <= tag_d;
      rbuf_q        <= rbuf_d;
      ram_addr_q    <= ram_addr_d;
      ram_dout_q    <= ram_dout_d;
      ram_wr_q      <= ram_wr_d;
      inst_valid_q  <= inst_valid_d;
      data_valid_q  <= data_valid_d;
      inst_data_q   <= inst_data_d;
      data_rdata_q  <= data_rdata_d;
      inst_addr_o_q <= inst_addr_o_d;
      busy_q        <= busy_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_dout    = ram_dout_q;
  assign ram_wr      = ram_wr_q;
  assign inst_valid  = inst_valid_q & ~flush;
  assign inst_data   = inst_data_q;
  assign inst_addr_o = inst_addr_o_q;
  assign data_valid  = data_valid_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = busy_q;
  // ready is held low while reset is asserted so every output reads 0
  assign data_ready  = (state_q == IDLE) & ~rst;
  assign inst_ready  = (state_q == IDLE) & ~data_req & ~flush & ~rst;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: directed scenarios plus randomized transactions checked
// against a transaction-level byte-memory model.
module tb_mem_ctrl_arb;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        rst, flush, inst_req, data_req, data_req3, data_we;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [1:0]  data_size;

  logic [7:0]  ram_din, ram_dout, ram_din3, ram_dout3;
  logic [31:0] ram_addr, ram_addr3;
  logic        ram_wr, ram_wr3;
  logic        inst_ready, inst_valid, data_ready, data_valid, busy;
  logic        inst_ready3, inst_valid3, data_ready3, data_valid3, busy3;
  logic [31:0] inst_data, inst_addr_o, data_rdata;
  logic [31:0] inst_data3, inst_addr_o3, data_rdata3;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  mem3    [0:255];
  logic [31:0] hist1;
  logic [31:0] hist3   [0:2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_ctrl_arb #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_addr_o(inst_addr_o),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_size(data_size), .data_ready(data_ready),
    .data_valid(data_valid), .data_rdata(data_rdata), .busy(busy)
  );

  mem_ctrl_arb #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .ram_din(ram_din3), .ram_dout(ram_dout3), .ram_addr(ram_addr3), .ram_wr(ram_wr3),
    .inst_req(1'b0), .inst_addr(inst_addr), .inst_ready(inst_ready3),
    .inst_valid(inst_valid3), .inst_data(inst_data3), .inst_addr_o(inst_addr_o3),
    .data_req(data_req3), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_size(data_size), .data_ready(data_ready3),
    .data_valid(data_valid3), .data_rdata(data_rdata3), .busy(busy3)
  );

  // RAM models: byte read returns after the configured number of cycles
  assign ram_din  = mem[hist1[15:0]];
  assign ram_din3 = mem3[hist3[2][7:0]];

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[15:0]] <= ram_dout;
    if (ram_wr3) mem3[ram_addr3[7:0]] <= ram_dout3;
    hist1    <= ram_addr;
    hist3[0] <= ram_addr3;
    hist3[1] <= hist3[0];
    hist3[2] <= hist3[1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input bit is_inst, input logic [1:0] size);
    if (is_inst) return 4;
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ak = a + 32'(k);
      v = v | (32'(ref_mem[ak[15:0]]) << (8 * k));
    end
    return v;
  endfunction

  // One transaction on u_dut; checks acceptance, per-byte RAM traffic, latency and result
  task automatic do_txn(input bit is_inst, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata, output logic [31:0] got);
    int n, lat_exp, seen;
    logic [31:0] exp, ak;
    n       = nbytes(is_inst, size);
    exp     = ref_read(addr, n);
    lat_exp = we ? n + 1 : n + LAT1 + 1;
    got     = 32'h0;
    seen    = 0;
    @(negedge clk);
    if (is_inst) begin
      inst_req = 1'b1; inst_addr = addr;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_size = size; data_wdata = wdata;
    end
    #1;
    check_eq("ready", is_inst ? inst_ready : data_ready, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c <= n) begin
        ak = addr + 32'(c - 1);
        check_eq("ram_addr", ram_addr, ak);
        check_eq("ram_wr", ram_wr, we);
        if (we) check_eq("ram_dout", ram_dout, 8'(wdata >> (8 * (c - 1))));
      end else begin
        check_eq("ram_wr_idle", ram_wr, 1'b0);
      end
      check_eq("other_valid", is_inst ? data_valid : inst_valid, 1'b0);
      if (is_inst ? inst_valid : data_valid) begin
        seen = c;
        got  = is_inst ? inst_data : data_rdata;
        if (is_inst) check_eq("inst_addr_o", inst_addr_o, addr);
        break;
      end
      @(negedge clk);
    end
    check_eq(we ? "store_lat" : "read_lat", 64'(seen), 64'(lat_exp));
    if (!we) check_eq(is_inst ? "fetch_data" : "load_data", got, exp);
    if (we) begin
      for (int k = 0; k < n; k++) begin
        ak = addr + 32'(k);
        ref_mem[ak[15:0]] = 8'(wdata >> (8 * k));
      end
    end
    @(negedge clk);
    check_eq("busy_after", busy, 1'b0);
  endtask

  initial begin
    logic [31:0] got, v;
    int seen, ci;
    bit ii, ww;
    logic [31:0] ra;

    rst = 1'b1; flush = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_req3 = 1'b0;
    data_we = 1'b0; inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_size = 2'd0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     <= 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    mem[16'h1000] <= 8'h13; mem[16'h1001] <= 8'h05; mem[16'h1002] <= 8'h00; mem[16'h1003] <= 8'h00;
    ref_mem[16'h1000] = 8'h13; ref_mem[16'h1001] = 8'h05; ref_mem[16'h1002] = 8'h00; ref_mem[16'h1003] = 8'h00;
    for (int i = 0; i < 256; i++) mem3[i] <= 8'(i ^ 8'h3C);
    mem3[7] <= 8'h80;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ram_wr", ram_wr, 1'b0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_data_ready", data_ready, 1'b0);
    check_eq("rst_valids", {inst_valid, data_valid}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_data_ready", data_ready, 1'b1);
    check_eq("idle_busy", busy, 1'b0);

    // fetch of a known instruction word
    do_txn(1'b1, 1'b0, 32'h1000, 2'd0, 32'h0, got);
    check_eq("tp_fetch_word", got, 32'h0000_0513);

    // simultaneous requests: data wins, fetch follows after one IDLE cycle
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20; data_size = 2'd2;
    inst_req = 1'b1; inst_addr = 32'h1000;
    #1;
    check_eq("arb_data_ready", data_ready, 1'b1);
    check_eq("arb_inst_ready", inst_ready, 1'b0);
    @(negedge clk);
    data_req = 1'b0;
    check_eq("arb_busy_inst_ready", inst_ready, 1'b0);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (data_valid) begin seen = c; got = data_rdata; break; end
      @(negedge clk);
    end
    check_eq("arb_load_lat", 64'(seen), 64'(4 + LAT1 + 1));
    check_eq("arb_load_data", got, ref_read(32'h20, 4));
    @(negedge clk);
    #1;
    check_eq("arb_fetch_ready", inst_ready, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (inst_valid) begin seen = c; got = inst_data; break; end
      @(negedge clk);
    end
    check_eq("arb_fetch_lat", 64'(seen), 64'(6));
    check_eq("arb_fetch_data", got, 32'h0000_0513);
    @(negedge clk);

    // store half across a 64 KiB boundary
    v = 32'h0;
    do_txn(1'b0, 1'b1, 32'h0003_FFFF, 2'd1, 32'hAABB_CCDD, got);
    check_eq("st_byte0", mem[16'hFFFF], 8'hDD);
    check_eq("st_byte1", mem[16'h0000], 8'hCC);
    check_eq("st_untouched", mem[16'h0001], 8'(1 * 37 + 11));

    // load byte on the latency-3 instance, zero-extended
    @(negedge clk);
    data_req3 = 1'b1; data_we = 1'b0; data_addr = 32'h7; data_size = 2'd0;
    #1;
    check_eq("lat3_ready", data_ready3, 1'b1);
    @(negedge clk);
    data_req3 = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (data_valid3) begin seen = c; got = data_rdata3; break; end
      @(negedge clk);
    end
    check_eq("lat3_load_lat", 64'(seen), 64'(5));
    check_eq("lat3_load_data", got, 32'h0000_0080);
    @(negedge clk);

    // flush during a fetch aborts it; the next fetch returns the right word
    inst_req = 1'b1; inst_addr = 32'h1000;
    #1;
    check_eq("fl_ready", inst_ready, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
    check_eq("fl_no_valid1", inst_valid, 1'b0);
    @(negedge clk);
    check_eq("fl_no_valid2", inst_valid, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("fl_no_valid3", inst_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    inst_req = 1'b1;
    #1;
    check_eq("fl_busy_cleared", busy, 1'b0);
    check_eq("fl_reaccept", inst_ready, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (inst_valid) begin seen = c; got = inst_data; break; end
      @(negedge clk);
    end
    check_eq("fl_refetch_lat", 64'(seen), 64'(6));
    check_eq("fl_refetch_data", got, 32'h0000_0513);
    @(negedge clk);

    // reset in the middle of a word store
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h200; data_size = 2'd2; data_wdata = 32'h1122_3344;
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mr_ram_wr", ram_wr, 1'b0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_ram_addr", ram_addr, 32'h0);
    check_eq("mr_ram_dout", ram_dout, 8'h00);
    check_eq("mr_ready", {data_ready, inst_ready}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("mr_no_valid", data_valid, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_idle", busy, 1'b0);
    check_eq("mr_mem0", mem[16'h0200], 8'h44);
    check_eq("mr_mem1", mem[16'h0201], 8'h33);
    check_eq("mr_mem2_untouched", mem[16'h0202], 8'(16'h0202 * 37 + 11));
    ref_mem[16'h0200] = 8'h44;
    ref_mem[16'h0201] = 8'h33;

    // randomized mix of fetches, loads and stores, including wrap-around addresses
    for (int i = 0; i < 40; i++) begin
      ci = int'($urandom_range(0, 2));
      ii = (ci == 0);
      ww = !ii && ($urandom_range(0, 1) == 1);
      ra = (i % 10 == 9) ? 32'hFFFF_FFFD : 32'h100 + 32'($urandom_range(0, 63));
      do_txn(ii, ww, ra, 2'($urandom_range(0, 3)), $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
